// File: rtl/deserializer_sipo.sv
// Serial-in/parallel-out receive stage: samples a framed, LSB-first serial line on bit strobes
// and presents each good word on BUFF with a ready/ack handshake plus error pulses.
module deserializer_sipo #(
    parameter int DATA_WIDTH = 8,
    parameter int PARITY_EN  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic                  shift,
    input  logic                  ack,
    output logic [DATA_WIDTH-1:0] BUFF,
    output logic                  ready,
    output logic                  RX_active,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  overrun
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state;
    logic [CW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] sreg;
    logic                  par_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            sreg       <= '0;
            par_bad    <= 1'b0;
            BUFF       <= '0;
            ready      <= 1'b0;
            RX_active  <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            // NOTE: pulses default low every clk so they stay one cycle wide whatever the strobe spacing.
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            if (ack) ready <= 1'b0;

            if (shift) begin
                unique case (state)
                    IDLE: begin
                        if (!rx_in) begin
                            state     <= DATA;
                            bit_cnt   <= '0;
                            par_bad   <= 1'b0;
                            RX_active <= 1'b1;
                        end
                    end
                    DATA: begin
                        sreg    <= {rx_in, sreg[DATA_WIDTH-1:1]};
                        bit_cnt <= bit_cnt + CW'(1);
                        if (bit_cnt == LAST_BIT)
                            state <= (PARITY_EN != 0) ? PARITY : STOP;
                    end
                    PARITY: begin
                        par_bad <= (^sreg) ^ rx_in;
                        state   <= STOP;
                    end
                    STOP: begin
                        state     <= IDLE;
                        RX_active <= 1'b0;
                        if (!rx_in) begin
                            frame_err <= 1'b1;
                        end else if (par_bad) begin
                            parity_err <= 1'b1;
                        end else begin
                            // A commit overrides a same-cycle ack; overrun only if the old word was never taken.
                            BUFF    <= sreg;
                            ready   <= 1'b1;
                            overrun <= ready & ~ack;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_deserializer_sipo.sv
// Directed bench for deserializer_sipo (DATA_WIDTH = 8, PARITY_EN = 1) with hand-computed expectations.
module tb_deserializer_sipo;

    localparam int DW = 8;

    logic          tb_clk = 1'b0;
    logic          rst, rx_in, shift, ack;
    logic [DW-1:0] BUFF;
    logic          ready, RX_active, parity_err, frame_err, overrun;

    int checks = 0;
    int errors = 0;

    always #5 tb_clk = ~tb_clk;

    deserializer_sipo #(.DATA_WIDTH(DW), .PARITY_EN(1)) dut (
        .clk       (tb_clk),
        .rst       (rst),
        .rx_in     (rx_in),
        .shift     (shift),
        .ack       (ack),
        .BUFF      (BUFF),
        .ready     (ready),
        .RX_active (RX_active),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string t, input logic [DW-1:0] b, input logic rdy,
                              input logic pe, input logic fe, input logic ov);
        check({t, ".BUFF"}, BUFF, b);
        check({t, ".ready"}, ready, rdy);
        check({t, ".parity_err"}, parity_err, pe);
        check({t, ".frame_err"}, frame_err, fe);
        check({t, ".overrun"}, overrun, ov);
    endtask

    // Drive one strobe; gap idle cycles (shift low) precede it. Returns #1 after the sampling edge.
    task automatic strobe(input logic b, input int gap);
        if (gap > 0) begin
            shift = 1'b0;
            repeat (gap) @(posedge tb_clk);
            #1;
        end
        rx_in = b;
        shift = 1'b1;
        @(posedge tb_clk);
        #1;
    endtask

    task automatic idle(input int n);
        shift = 1'b0;
        rx_in = 1'b1;
        repeat (n) @(posedge tb_clk);
        #1;
    endtask

    // Full frame; even parity bit is computed here and optionally inverted.
    task automatic send_frame(input logic [DW-1:0] d, input logic flip_par, input logic stop_bit,
                              input logic ack_on_stop, input int gap);
        strobe(1'b0, gap);
        check("active_after_start", RX_active, 1'b1);
        for (int i = 0; i < DW; i++) strobe(d[i], gap);
        strobe((^d) ^ flip_par, gap);
        if (gap > 0) begin
            shift = 1'b0;
            repeat (gap) @(posedge tb_clk);
            #1;
        end
        ack = ack_on_stop;
        strobe(stop_bit, 0);
        ack   = 1'b0;
        shift = 1'b0;
        rx_in = 1'b1;
        check("active_after_stop", RX_active, 1'b0);
    endtask

    initial begin
        logic seen;
        rst = 1'b1; rx_in = 1'b1; shift = 1'b0; ack = 1'b0;
        repeat (3) @(posedge tb_clk);
        #1;
        check("reset.RX_active", RX_active, 1'b0);
        expect_out("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Idle line with sparse strobes: nothing may happen.
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            shift = (i % 4 == 0);
            rx_in = 1'b1;
            @(posedge tb_clk);
            #1;
            seen |= RX_active | ready | parity_err | frame_err | overrun;
        end
        shift = 1'b0;
        check("idle.any_activity", seen, 1'b0);
        check("idle.BUFF", BUFF, 8'h00);

        // Good frame A5 with spaced strobes.
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 2);
        expect_out("good_a5", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        ack = 1'b1;
        @(posedge tb_clk);
        #1;
        ack = 1'b0;
        check("ack.ready", ready, 1'b0);

        // Parity error: pulse one cycle, no commit.
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1);
        expect_out("parity", 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);
        check("parity.pulse_width", parity_err, 1'b0);

        // Framing error: stop bit 0.
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1);
        expect_out("frame", 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(1);
        check("frame.pulse_width", frame_err, 1'b0);

        // Back-to-back frames, no ack: overrun on the second commit.
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 0);
        expect_out("b2b_first", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(8'hC3, 1'b0, 1'b1, 1'b0, 0);
        expect_out("b2b_overrun", 8'hC3, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(1);
        check("overrun.pulse_width", overrun, 1'b0);
        check("overrun.ready_held", ready, 1'b1);

        // Same again, ack coinciding with the second commit.
        ack = 1'b1;
        @(posedge tb_clk);
        #1;
        ack = 1'b0;
        check("pre_ack.ready", ready, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 0);
        expect_out("ack_first", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(8'hC3, 1'b0, 1'b1, 1'b1, 0);
        expect_out("ack_same_cycle", 8'hC3, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);

        // Reset after the 4th data strobe of FF, then 81 with shift held high.
        strobe(1'b0, 0);
        for (int i = 0; i < 4; i++) strobe(1'b1, 0);
        check("midframe.RX_active_pre", RX_active, 1'b1);
        shift = 1'b0;
        rst   = 1'b1;
        @(posedge tb_clk);
        #1;
        rst = 1'b0;
        check("midframe.RX_active", RX_active, 1'b0);
        expect_out("midframe", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h81, 1'b0, 1'b1, 1'b0, 0);
        expect_out("after_reset_81", 8'h81, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
